// File: rtl/ldm_read_sequencer.sv
// Streams weight/activation operand pairs out of LDM0/LDM1 over the shared CTRL
// port-A bus, yielding to AXI on LDM0 and strobing each aligned pair.
module ldm_read_sequencer #(
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 7
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_in,
  input  logic [5:0]            w_base_in,
  input  logic [5:0]            x_base_in,
  input  logic [LEN_WIDTH-1:0]  len_in,
  input  logic                  axi_req_in,
  output logic                  CTRL_LDM_ena_out,
  output logic                  CTRL_LDM_wea_out,
  output logic [ADDR_WIDTH-1:0] CTRL_LDM_addra_out,
  output logic                  CTRL_LDM_enb_out,
  output logic                  CTRL_LDM_web_out,
  output logic [ADDR_WIDTH-1:0] CTRL_LDM_addrb_out,
  output logic                  pair_valid_out,
  output logic [5:0]            pair_idx_out,
  output logic                  pair_last_out,
  output logic                  busy_out,
  output logic                  done_out
);

  typedef enum logic [1:0] {IDLE, RD_W, RD_X, DONE} state_t;

  state_t     state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [6:0] len_q, len_d;
  logic [5:0] wb_q, wb_d;
  logic [5:0] xb_q, xb_d;
  logic       pv_q, pv_d;
  logic [5:0] pidx_q, pidx_d;
  logic       plast_q, plast_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       is_last;
  logic [5:0] w_off, x_off;

  function automatic logic [6:0] sat_len(input logic [LEN_WIDTH-1:0] l);
    if (l > LEN_WIDTH'(64)) return 7'd64;
    return 7'(l);
  endfunction

  assign is_last = ({1'b0, idx_q} == (len_q - 7'd1));
  // Offsets wrap inside the 64-word bank; the bank bits are never touched.
  assign w_off   = wb_q + idx_q;
  assign x_off   = xb_q + idx_q;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      wb_q    <= '0;
      xb_q    <= '0;
      pv_q    <= 1'b0;
      pidx_q  <= '0;
      plast_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      wb_q    <= wb_d;
      xb_q    <= xb_d;
      pv_q    <= pv_d;
      pidx_q  <= pidx_d;
      plast_q <= plast_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    wb_d    = wb_q;
    xb_d    = xb_q;
    pv_d    = 1'b0;
    pidx_d  = pidx_q;
    plast_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          if (len_in != '0) begin
            wb_d    = w_base_in;
            xb_d    = x_base_in;
            len_d   = sat_len(len_in);
            idx_d   = '0;
            state_d = RD_W;
          end else begin
            state_d = DONE;
          end
        end
      end
      RD_W: begin
        if (!axi_req_in) state_d = RD_X;
      end
      RD_X: begin
        // An AXI read here overwrites the held LDM0 weight, so the pair is retried.
        if (axi_req_in) begin
          state_d = RD_W;
        end else begin
          pv_d    = 1'b1;
          pidx_d  = idx_q;
          plast_d = is_last;
          if (is_last) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 6'd1;
            state_d = RD_W;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  always_comb begin
    CTRL_LDM_ena_out   = 1'b0;
    CTRL_LDM_addra_out = '0;
    case (state_q)
      RD_W: begin
        CTRL_LDM_ena_out   = !axi_req_in;
        CTRL_LDM_addra_out = ADDR_WIDTH'({2'b00, w_off});
      end
      RD_X: begin
        CTRL_LDM_ena_out   = 1'b1;
        CTRL_LDM_addra_out = ADDR_WIDTH'({2'b01, x_off});
      end
      default: ;
    endcase
  end

  assign CTRL_LDM_wea_out   = 1'b0;
  assign CTRL_LDM_enb_out   = 1'b0;
  assign CTRL_LDM_web_out   = 1'b0;
  assign CTRL_LDM_addrb_out = '0;
  assign pair_valid_out     = pv_q;
  assign pair_idx_out       = pidx_q;
  assign pair_last_out      = plast_q;
  assign busy_out           = busy_q;
  assign done_out           = done_q;

endmodule

// File: doc/ldm_read_sequencer.md
# ldm_read_sequencer

Controller that drives the CTRL read ports of the LSU to stream operand pairs (weight from LDM0, activation from LDM1) to the ALU. Both operands share the CTRL port-A address bus, so it issues the weight read and the activation read on alternating cycles. It relies on LDM0 `douta` holding its value while that memory is disabled. It gives way to AXI traffic on LDM0 and flags each aligned pair with a valid strobe.

## Interface
- `ADDR_WIDTH`, 8: LDM address width. `[7:6]` selects the bank (00 = LDM0, 01 = LDM1); `[5:0]` is the word offset.
- `LEN_WIDTH`, 7: width of the pair-count input.
- `clk` in 1: single clock. All logic is on its rising edge.
- `rst_n` in 1: reset. **Synchronous, active-high** (1 = reset).
- `start_in` in 1: one-cycle request to begin a stream. Sampled only in IDLE.
- `w_base_in` in 6: LDM0 word offset of weight 0. Latched on accept.
- `x_base_in` in 6: LDM1 word offset of activation 0. Latched on accept.
- `len_in` in `LEN_WIDTH`: number of pairs. 0 means no reads; values above 64 saturate to 64.
- `axi_req_in` in 1: AXI is accessing LDM0 port A this cycle (`AXI_LDM_ena_in` and `AXI_LDM_addra_in[7:6]==0`).
- `CTRL_LDM_ena_out` out 1: LSU CTRL port-A enable.
- `CTRL_LDM_wea_out` out 1: constant 0.
- `CTRL_LDM_addra_out` out `ADDR_WIDTH`: LSU CTRL port-A address.
- `CTRL_LDM_enb_out`, `CTRL_LDM_web_out` out 1: constant 0.
- `CTRL_LDM_addrb_out` out `ADDR_WIDTH`: constant 0.
- `pair_valid_out` out 1: the LSU `dout0`/`dout1` outputs hold weight[idx] and activation[idx] this cycle.
- `pair_idx_out` out 6: index of the valid pair.
- `pair_last_out` out 1: the valid pair is the final one.
- `busy_out` out 1: state is not IDLE.
- `done_out` out 1: one-cycle completion pulse.

## Operation
- States: IDLE, RD_W, RD_X, DONE. `idx` is a 6-bit counter; `len_q` is a 7-bit register (1..64).
- **IDLE**
  - `start_in` with `len_in`≠0: latch the bases, set `len_q = min(len_in, 64)`, set `idx = 0`, go to RD_W.
  - `start_in` with `len_in`=0: go to DONE with no reads.
  - No `start_in`: stay.
- **RD_W**
  - `axi_req_in`=1: `ena` = 0 and stay (stall; AXI has priority on LDM0).
  - Otherwise: `ena` = 1, `addra = {2'b00, w_base+idx}`, go to RD_X.
- **RD_X**
  - `ena` = 1, `addra = {2'b01, x_base+idx}`.
  - `axi_req_in`=1 in this cycle: the AXI read corrupts LDM0 `douta`. The pair is discarded (no valid). Go back to RD_W with the same `idx` (retry).
  - Otherwise: a pair is valid next cycle. If `idx == len_q-1`, go to DONE; else increment `idx` and go to RD_W.
- **DONE**: assert `done_out` for one cycle. If the final pair is pending, also assert `pair_valid_out` and `pair_last_out` this cycle. Then go to IDLE.
- Pair-valid register: loaded in any cycle that completes a clean RD_X. Drives `pair_valid_out`, `pair_idx_out` (= the issued `idx`) and `pair_last_out` on the following cycle.
- Address offsets wrap modulo 64. `base+idx` never carries into the bank bits.
- `ena` and `addra` are combinational from state, `idx` and `axi_req_in`. All other outputs are registered.
- `start_in` outside IDLE is ignored.

## Timing
- Reset values: state IDLE; `idx`, `len_q`, bases 0. All outputs 0: every enable, address, valid and last, `pair_idx_out`, `busy_out`, `done_out`.
- Reset mid-stream: the next cycle is IDLE. No `done_out`; any pending valid is dropped.
- Uncontended stream of N pairs, with `start_in` sampled at cycle 0:
  - RD_W for `idx` k at cycle 2k+1; RD_X at cycle 2k+2.
  - `pair_valid_out` for k at cycle 2k+3.
  - Last pair valid together with `done_out` at cycle 2N+1.
  - `busy_out` high over cycles 1..2N+1.
- `len_in`=0: DONE at cycle 1 with `done_out`=1 and `pair_valid_out`=0.
- Each RD_W stall cycle or RD_X retry adds cycles (a retry adds two). Pair order and indices are unchanged.
- Read latency of LDM0/LDM1 is 1 cycle. LDM0 `douta` must hold through the RD_X cycle.

## Test plan
- Reset check: assert `rst_n`=1 for 2 cycles -> all outputs 0, `busy_out`=0.
- Basic stream: `w_base`=0x05, `x_base`=0x10, `len`=3, no AXI traffic.
  - Addresses issued in order: 0x05, 0x50, 0x06, 0x51, 0x07, 0x52.
  - Valid at cycles 3, 5 and 7 with idx 0, 1, 2; `last` at 7; `done_out` at 7.
  - LSU `dout0`/`dout1` match the preloaded memory.
- Wrap: `w_base`=0x3E, `x_base`=0x3F, `len`=3.
  - Weight addresses 0x3E, 0x3F, 0x00.
  - Activation addresses 0x7F, 0x40, 0x41.
- AXI contention, `len`=2:
  - `axi_req_in` high for 3 cycles during RD_W of idx 1 -> `ena`=0 for those 3 cycles, `done_out` at cycle 8.
  - `axi_req_in` pulse during RD_X of idx 0 -> no valid for idx 0; idx 0 reissued at 0x00 then 0x40, then a correct pair.
- Edge requests:
  - `len`=0 -> `done_out` at cycle 1, no enables asserted.
  - `len`=100 -> exactly 64 pairs delivered.
  - `start_in` while busy -> ignored.
- Reset mid-stream: `rst_n` asserted at cycle 4 of a `len`=5 stream -> IDLE next cycle, no `done_out`. A new start then runs cleanly.
